fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the cache's processor-side Sysbus port.
- Requests 64-byte lines (8 × 64-bit beats) at the line-aligned PC and buffers each line.
- Issues 32-bit instructions one at a time to decode over a valid/ready handshake.
- Handles sequential line advance and decode/execute redirects.

---
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: Sysbus request/response, decode issue
// handshake and redirect input.
interface fetch_unit_if #(
   parameter int DW = 64,
   parameter int TW = 13
);
   logic          bus_reqcyc;
   logic [DW-1:0] bus_req;
   logic [TW-1:0] bus_reqtag;
   logic          bus_reqack;
   logic          bus_respcyc;
   logic [DW-1:0] bus_resp;
   logic [TW-1:0] bus_resptag;
   logic          bus_respack;
   logic          inst_valid;
   logic [31:0]   inst;
   logic [63:0]   inst_pc;
   logic          inst_ready;
   logic          redirect_valid;
   logic [63:0]   redirect_pc;

   modport master (
      output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      output inst_valid, inst, inst_pc,
      input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      input  inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
      input  inst_valid, inst, inst_pc,
      output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      output inst_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: requests 64-byte lines over Sysbus, buffers
// them and issues 32-bit words to decode, handling redirects.
module fetch_unit #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int LINE_BEATS     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [63:0]  entry,
   fetch_unit_if.master bus
);
   localparam logic       SYSBUS_READ   = 1'b1;
   localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
   localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG =
      {SYSBUS_READ, SYSBUS_MEMORY, 8'b0};
   localparam int CW = $clog2(LINE_BEATS);
   localparam logic [CW-1:0] LAST = CW'(LINE_BEATS - 1);

   typedef enum logic [2:0] {
      IDLE, REQ, RESP, ISSUE, DRAIN
   } state_e;

   state_e                    state_q, state_d;
   logic [63:0]               pc_q, pc_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [BUS_DATA_WIDTH-1:0] buf_q [LINE_BEATS];

   logic        beat_ack;
   logic        last_beat;
   logic        fire;
   logic [63:0] rpc;
   logic [63:0] beat;

   assign beat_ack  = ((state_q == RESP) || (state_q == DRAIN))
                      && bus.bus_respcyc && !reset;
   assign last_beat = beat_ack && (cnt_q == LAST);
   assign fire      = (state_q == ISSUE) && bus.inst_ready;
   assign rpc       = {bus.redirect_pc[63:2], 2'b00};
   assign beat      = buf_q[pc_q[5:3]];

   logic unused_ok;
   assign unused_ok = ^{bus.bus_resptag, bus.redirect_pc[1:0],
                        entry[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= {entry[63:2], 2'b00};
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == RESP && beat_ack)
         buf_q[cnt_q] <= bus.bus_resp;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (bus.bus_reqack) begin
               state_d = RESP;
               cnt_d   = '0;
            end
         end
         RESP, DRAIN: begin
            if (beat_ack) cnt_d = cnt_q + 1'b1;
            if (last_beat)
               state_d = (state_q == RESP) ? ISSUE : REQ;
         end
         ISSUE: begin
            if (fire) begin
               pc_d = pc_q + 64'd4;
               if (pc_q[5:2] == 4'hF) state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
      // redirect wins; an accepted or in-flight line is drained
      if (bus.redirect_valid) begin
         pc_d = rpc;
         unique case (state_q)
            REQ:
               state_d = bus.bus_reqack ? DRAIN : REQ;
            RESP, DRAIN:
               state_d = last_beat ? REQ : DRAIN;
            default: state_d = REQ;
         endcase
      end
   end

   always_comb begin
      bus.bus_reqcyc  = 1'b0;
      bus.bus_req     = '0;
      bus.bus_reqtag  = '0;
      bus.bus_respack = 1'b0;
      bus.inst_valid  = 1'b0;
      bus.inst        = '0;
      bus.inst_pc     = '0;
      if (!reset) begin
         unique case (state_q)
            REQ: begin
               bus.bus_reqcyc = 1'b1;
               bus.bus_req    = {pc_q[63:6], 6'b0};
               bus.bus_reqtag = REQ_TAG;
            end
            RESP, DRAIN: bus.bus_respack = bus.bus_respcyc;
            ISSUE: begin
               bus.inst_valid = 1'b1;
               bus.inst       = pc_q[2] ? beat[63:32] : beat[31:0];
               bus.inst_pc    = pc_q;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: line fetch, issue order,
// backpressure, redirect drain, response gaps, reset mid-line.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] entry;
   int          total = 0;
   int          bad   = 0;

   fetch_unit_if #(.DW(64), .TW(13)) bus ();

   fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .entry (entry),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [12:0] TAG = 13'h1100;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      logic any;
      any = bus.bus_reqcyc | bus.bus_respack | bus.inst_valid
            | (|bus.bus_req) | (|bus.bus_reqtag)
            | (|bus.inst) | (|bus.inst_pc);
      chk(tag, {63'b0, any}, 64'd0);
   endtask

   task automatic do_reset(input logic [63:0] e);
      reset = 1'b1;
      entry = e;
      bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.bus_reqack = 1'b0;
      #1;
      chk_zero("zero_in_reset");
      tick();
      reset = 1'b0;
      bus.bus_respcyc = 1'b0;
      #1;
      chk_zero("zero_after_reset");
   endtask

   task automatic wait_req(input string tag, input logic [63:0] addr,
                           output int n);
      n = 0;
      while (!bus.bus_reqcyc && n < 40) begin
         chk({tag, "_noinst"}, {63'b0, bus.inst_valid}, 64'd0);
         tick();
         n++;
      end
      chk({tag, "_reqcyc"}, {63'b0, bus.bus_reqcyc}, 64'd1);
      chk({tag, "_addr"}, bus.bus_req, addr);
      chk({tag, "_tag"}, {51'b0, bus.bus_reqtag}, {51'b0, TAG});
      tick();
      chk({tag, "_hold1"}, bus.bus_req, addr);
      tick();
      chk({tag, "_hold2"}, bus.bus_req, addr);
      bus.bus_reqack = 1'b1;
      tick();
      bus.bus_reqack = 1'b0;
   endtask

   task automatic send_beats(input int lo, input int hi,
                             input bit gaps);
      for (int k = lo; k <= hi; k++) begin
         if (gaps) begin
            for (int g = 0; g < (k % 3) + 1; g++) begin
               bus.bus_respcyc = 1'b0;
               #1;
               chk("gap_noack", {63'b0, bus.bus_respack}, 64'd0);
               tick();
            end
         end
         bus.bus_respcyc = 1'b1;
         bus.bus_resp = {32'(2*k+1), 32'(2*k)};
         #1;
         chk("beat_ack", {63'b0, bus.bus_respack}, 64'd1);
         tick();
      end
      bus.bus_respcyc = 1'b0;
      #1;
   endtask

   task automatic issue(input logic [31:0] w, input logic [63:0] pc);
      chk("iss_valid", {63'b0, bus.inst_valid}, 64'd1);
      chk("iss_inst", {32'b0, bus.inst}, {32'b0, w});
      chk("iss_pc", bus.inst_pc, pc);
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      #1;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      entry = '0;
      bus.bus_reqack = 1'b0;
      bus.bus_respcyc = 1'b0;
      bus.bus_resp = '0;
      bus.bus_resptag = '0;
      bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      tick();

      // full line from 0x1000
      do_reset(64'h1000);
      wait_req("t1", 64'h1000, n);
      chk("t1_req_lat", 64'(n), 64'd1);
      send_beats(0, 7, 1'b0);
      for (int i = 0; i < 16; i++)
         issue(32'(i), 64'h1000 + 64'(4*i));
      chk("t1_next_valid", {63'b0, bus.inst_valid}, 64'd0);
      chk("t1_next_req", {63'b0, bus.bus_reqcyc}, 64'd1);
      chk("t1_next_addr", bus.bus_req, 64'h1040);

      // mid-line entry
      do_reset(64'h1038);
      wait_req("t2", 64'h1000, n);
      send_beats(0, 7, 1'b0);
      issue(32'hE, 64'h1038);
      issue(32'hF, 64'h103C);
      wait_req("t2n", 64'h1040, n);
      chk("t2_next_lat", 64'(n), 64'd0);

      // backpressure
      do_reset(64'h1000);
      wait_req("t3", 64'h1000, n);
      send_beats(0, 7, 1'b0);
      issue(32'h0, 64'h1000);
      issue(32'h1, 64'h1004);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", {63'b0, bus.inst_valid}, 64'd1);
         chk("bp_inst", {32'b0, bus.inst}, 64'h2);
         chk("bp_pc", bus.inst_pc, 64'h1008);
         tick();
      end
      issue(32'h2, 64'h1008);
      issue(32'h3, 64'h100C);

      // redirect during response
      do_reset(64'h1000);
      wait_req("t4", 64'h1000, n);
      send_beats(0, 3, 1'b0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 64'h2006;
      #1;
      chk("rd_noack", {63'b0, bus.bus_respack}, 64'd0);
      tick();
      bus.redirect_valid = 1'b0;
      send_beats(4, 7, 1'b0);
      wait_req("t4r", 64'h2000, n);
      send_beats(0, 7, 1'b0);
      issue(32'h1, 64'h2004);
      issue(32'h2, 64'h2008);

      // response gaps
      do_reset(64'h1000);
      wait_req("t5", 64'h1000, n);
      send_beats(0, 7, 1'b1);
      for (int i = 0; i < 4; i++)
         issue(32'(i), 64'h1000 + 64'(4*i));

      // reset mid-line
      do_reset(64'h1000);
      wait_req("t6a", 64'h1000, n);
      send_beats(0, 2, 1'b0);
      bus.bus_respcyc = 1'b1;
      do_reset(64'h3000);
      wait_req("t6", 64'h3000, n);
      chk("t6_req_lat", 64'(n), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
